// File: rtl/ha_array_pkg.sv
// Shared types and constants for the 8x8 ha_array reducer.
// Group layout: t holds sum bits at weight 2^i, b holds carry bits at weight 2^(i+2).
package ha_array_pkg;

   localparam int GROUPS = 4;
   localparam int T_W    = 9;
   localparam int B_W    = 7;
   localparam int P_W    = 16;
   localparam int G_W    = 10;
   localparam int A_W    = 17;

   typedef struct packed {
      logic [T_W-1:0] t;
      logic [B_W-1:0] b;
   } ha_group_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ha_group_value.sv
// Combinational value of one ha_array group: G = t + (b << 2), at most 1019.
module ha_group_value
   import ha_array_pkg::*;
(
   input  ha_group_t        i_grp,
   output logic [G_W-1:0]   o_g
);

   assign o_g = {1'b0, i_grp.t} + {1'b0, i_grp.b, 2'b00};

endmodule

// File: rtl/ha_array_reducer_8x8.sv
// Serial reducer: folds four captured ha_array groups into a 16-bit product, one group per cycle.
// Build macro HA_REDUCE_SAT_EN: saturate product to 16'hFFFF and raise overflow instead of wrapping.
module ha_array_reducer_8x8
   import ha_array_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [T_W-1:0]   ha_array_0_t,
   input  logic [B_W-1:0]   ha_array_0_b,
   input  logic [T_W-1:0]   ha_array_1_t,
   input  logic [B_W-1:0]   ha_array_1_b,
   input  logic [T_W-1:0]   ha_array_2_t,
   input  logic [B_W-1:0]   ha_array_2_b,
   input  logic [T_W-1:0]   ha_array_3_t,
   input  logic [B_W-1:0]   ha_array_3_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [P_W-1:0]   product,
   output logic             overflow
);

   // state | meaning
   // IDLE  | ready for a new group set
   // ACC   | adding group r_cnt into the accumulator
   // DONE  | product presented, waiting for out_ready

   state_e            r_state;
   logic [1:0]        r_cnt;
   ha_group_t         r_grp [GROUPS];
   logic [A_W-1:0]    r_acc;
   logic [P_W-1:0]    r_product;
   logic              r_overflow;
   logic              r_out_valid;
   logic              r_in_ready;

   logic [G_W-1:0]    w_g;
   logic [A_W-1:0]    w_term;
   logic [A_W-1:0]    w_acc_next;
   logic [P_W-1:0]    w_prod;
   logic              w_sat;

   ha_group_value u_group_value (
      .i_grp (r_grp[r_cnt]),
      .o_g   (w_g)
   );

   assign w_term     = {{(A_W-G_W){1'b0}}, w_g} << {r_cnt, 1'b0};
   assign w_acc_next = r_acc + w_term;

`ifdef HA_REDUCE_SAT_EN
   assign w_sat  = w_acc_next[A_W-1];
   assign w_prod = w_sat ? {P_W{1'b1}} : w_acc_next[P_W-1:0];
`else
   assign w_sat  = 1'b0;
   assign w_prod = w_acc_next[P_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= 2'd0;
         r_acc       <= '0;
         r_product   <= '0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         for (int i = 0; i < GROUPS; i++) r_grp[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_grp[0]   <= {ha_array_0_t, ha_array_0_b};
                  r_grp[1]   <= {ha_array_1_t, ha_array_1_b};
                  r_grp[2]   <= {ha_array_2_t, ha_array_2_b};
                  r_grp[3]   <= {ha_array_3_t, ha_array_3_b};
                  r_acc      <= '0;
                  r_cnt      <= 2'd0;
                  r_in_ready <= 1'b0;
                  r_state    <= ACC;
               end
            end
            ACC: begin
               r_acc <= w_acc_next;
               // Final group: take the result straight from the adder so DONE sees it.
               if (r_cnt == 2'd3) begin
                  r_product   <= w_prod;
                  r_overflow  <= w_sat;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   // Held low while rst_n is asserted; ready the moment reset is released.
   assign in_ready  = r_in_ready & rst_n;
   assign out_valid = r_out_valid;
   assign product   = r_product;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_ha_array_reducer_8x8.sv
// Directed bench for ha_array_reducer_8x8; expected products hand-computed (see HA_REDUCE_SAT_EN for the all-ones case).
module tb_ha_array_reducer_8x8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  vt [4];
   logic [6:0]  vb [4];
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ha_array_reducer_8x8 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_t (vt[0]),
      .ha_array_0_b (vb[0]),
      .ha_array_1_t (vt[1]),
      .ha_array_1_b (vb[1]),
      .ha_array_2_t (vt[2]),
      .ha_array_2_b (vb[2]),
      .ha_array_3_t (vt[3]),
      .ha_array_3_b (vb[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .overflow     (overflow)
   );

   task automatic set_all(input logic [8:0] t, input logic [6:0] b);
      for (int i = 0; i < 4; i++) begin
         vt[i] = t;
         vb[i] = b;
      end
   endtask

   // Offer the current vectors, then scramble them after the capture edge.
   task automatic handshake(output bit ok);
      int n = 0;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      set_all(9'h155, 7'h2A);
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_txn(output bit ok, output int lat, output logic [15:0] p, output logic ov);
      handshake(ok);
      wait_out(lat);
      p  = product;
      ov = overflow;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_all(9'h0, 7'h0);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_group0();
      bit ok; int lat; logic [15:0] p; logic ov;
      set_all(9'h0, 7'h0);
      vt[0] = 9'h001;
      run_txn(ok, lat, p, ov);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL g0_accept got in_ready=%b want 1", in_ready); end
      checks++; if (lat != 5) begin errors++; $display("FAIL g0_latency got %0d want 5", lat); end
      checks++; if (p !== 16'h0001) begin errors++; $display("FAIL g0_product got %h want 0001", p); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL g0_overflow got %b want 0", ov); end
   endtask

   task automatic test_group3();
      bit ok; int lat; logic [15:0] p; logic ov;
      set_all(9'h0, 7'h0);
      vt[3] = 9'h100;
      run_txn(ok, lat, p, ov);
      checks++; if (lat != 5) begin errors++; $display("FAIL g3_latency got %0d want 5", lat); end
      checks++; if (p !== 16'h4000) begin errors++; $display("FAIL g3_product got %h want 4000", p); end
   endtask

   task automatic test_all_b();
      bit ok; int lat; logic [15:0] p; logic ov;
      set_all(9'h0, 7'h7F);
      run_txn(ok, lat, p, ov);
      checks++; if (p !== 16'hA8AC) begin errors++; $display("FAIL allb_product got %h want a8ac", p); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL allb_overflow got %b want 0", ov); end
   endtask

   task automatic test_all_ones();
      bit ok; int lat; logic [15:0] p; logic ov;
      logic [15:0] exp_p; logic exp_ov;
`ifdef HA_REDUCE_SAT_EN
      exp_p = 16'hFFFF; exp_ov = 1'b1;
`else
      exp_p = 16'h5257; exp_ov = 1'b0;
`endif
      set_all(9'h1FF, 7'h7F);
      run_txn(ok, lat, p, ov);
      checks++; if (lat != 5) begin errors++; $display("FAIL ones_latency got %0d want 5", lat); end
      checks++; if (p !== exp_p) begin errors++; $display("FAIL ones_product got %h want %h", p, exp_p); end
      checks++; if (ov !== exp_ov) begin errors++; $display("FAIL ones_overflow got %b want %b", ov, exp_ov); end
   endtask

   task automatic test_backpressure();
      bit ok; int lat;
      set_all(9'h0, 7'h0);
      vt[0] = 9'h001;
      handshake(ok);
      wait_out(lat);
      checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency got %0d want 5", lat); end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_all(9'h0, 7'h0);
      vt[3] = 9'h100;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++; if (product !== 16'h0001) begin errors++; $display("FAIL bp_hold_product cycle %0d got %h want 0001", i, product); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", i, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cycle %0d got %b want 0", i, in_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      set_all(9'h155, 7'h2A);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got in_ready=%b want 0", in_ready); end
      wait_out(lat);
      checks++; if (lat != 5) begin errors++; $display("FAIL bp_second_latency got %0d want 5", lat); end
      checks++; if (product !== 16'h4000) begin errors++; $display("FAIL bp_second_product got %h want 4000", product); end
   endtask

   task automatic test_reset_mid_acc();
      bit ok; int lat; bit seen;
      logic [15:0] p; logic ov;
      set_all(9'h0, 7'h7F);
      handshake(ok);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b want 1", in_ready); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL mid_reset_product got %h want 0000", product); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (seen) begin errors++; $display("FAIL mid_reset_no_output got out_valid=1 want 0"); end
      set_all(9'h0, 7'h0);
      vt[1] = 9'h003;
      vb[2] = 7'h01;
      // 3<<2 + 4<<4 = 12 + 64 = 76
      run_txn(ok, lat, p, ov);
      checks++; if (lat != 5) begin errors++; $display("FAIL mid_after_latency got %0d want 5", lat); end
      checks++; if (p !== 16'd76) begin errors++; $display("FAIL mid_after_product got %h want 004c", p); end
   endtask

   initial begin
      test_reset();
      test_group0();
      test_group3();
      test_all_b();
      test_all_ones();
      test_backpressure();
      test_reset_mid_acc();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
